regfile_scan_reader: RTL and testbench

Sequential reader for the 16x16 register file: on a start pulse it walks register addresses 0 to NUM_REGS-1 through the file's read port and captures each word. It then presents that word and its index for display for a programmable dwell time. It sits between the RegFile_Alu read port and the board's hexTo7Seg digits. It provides the observation path that complements the switch/button load path into the register file.

---
 rtl/regfile_scan_reader_if.sv | 28 ++
 rtl/regfile_scan_reader.sv | 142 ++++++++++++++
 tb/tb_regfile_scan_reader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scan_reader_if.sv
// Bus between the scan reader, the register file read port and the display logic.
// The reader drives the read strobe/address and the display outputs; the peer side drives controls and read data.
interface regfile_scan_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              Start;
  logic              Pause;
  logic              Step;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;
  logic [DATA_W-1:0] ShowData;
  logic [ADDR_W-1:0] ShowAddr;
  logic              Valid;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, Pause, Step, RdData,
    output RdEn, RdAddr, ShowData, ShowAddr, Valid, Busy, Done
  );

  modport slave (
    output Start, Pause, Step, RdData,
    input  RdEn, RdAddr, ShowData, ShowAddr, Valid, Busy, Done
  );
endinterface

// File: rtl/regfile_scan_reader.sv
// Walks register addresses 0..NUM_REGS-1 through the register file read port and
// holds each captured word for display for DWELL cycles (Pause freezes, Step advances).
module regfile_scan_reader #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter int DWELL    = 50000000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  regfile_scan_reader_if.master  bus
);

  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LAT_W   = $clog2(READ_LAT + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHOW,
    S_DONE
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [LAT_W-1:0]    lat_cnt_q,   lat_cnt_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DATA_W-1:0]   show_data_q, show_data_d;
  logic [ADDR_W-1:0]   show_addr_q, show_addr_d;
  logic                valid_q,     valid_d;
  logic                rd_en_q,     rd_en_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                advance;

  // While paused only Step moves on; otherwise the dwell counter decides.
  assign advance = bus.Pause ? bus.Step : (dwell_cnt_q == DWELL_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d     = state_q;
    addr_d      = addr_q;
    lat_cnt_d   = lat_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    show_data_d = show_data_q;
    show_addr_d = show_addr_q;
    valid_d     = valid_q;
    rd_en_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_REQ;
          addr_d  = '0;
          valid_d = 1'b0;
          rd_en_d = 1'b1;
        end
      end
      S_REQ: begin
        lat_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          show_data_d = bus.RdData;
          show_addr_d = addr_q;
          valid_d     = 1'b1;
          dwell_cnt_d = '0;
          state_d     = S_SHOW;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_SHOW: begin
        if (!bus.Pause && !advance) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
        if (advance) begin
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_REQ;
            rd_en_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (Rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      lat_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      show_data_q <= '0;
      show_addr_q <= '0;
      valid_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lat_cnt_q   <= lat_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      show_data_q <= show_data_d;
      show_addr_q <= show_addr_d;
      valid_q     <= valid_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.RdEn     = rd_en_q;
  assign bus.RdAddr   = addr_q;
  assign bus.ShowData = show_data_q;
  assign bus.ShowAddr = show_addr_q;
  assign bus.Valid    = valid_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed/randomized bench for regfile_scan_reader: two instances (READ_LAT=1/DWELL=4 and
// READ_LAT=3/DWELL=2) checked against an expected event schedule derived from the cycle arithmetic.
module tb_regfile_scan_reader;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int LAT_A    = 1;
  localparam int DW_A     = 4;
  localparam int LAT_B    = 3;
  localparam int DW_B     = 2;
  localparam int MAXC     = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  regfile_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
  regfile_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();

  regfile_scan_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .READ_LAT(LAT_A), .DWELL(DW_A))
    dut_a (.Clk(clk), .Rst(rst_a), .bus(if_a.master));

  regfile_scan_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .READ_LAT(LAT_B), .DWELL(DW_B))
    dut_b (.Clk(clk), .Rst(rst_b), .bus(if_b.master));

  logic [DATA_W-1:0] regs [NUM_REGS];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic              rden;
    logic [ADDR_W-1:0] rdaddr;
    logic [DATA_W-1:0] sdata;
    logic [ADDR_W-1:0] saddr;
    logic              valid;
    logic              busy;
    logic              done;
  } snap_t;

  snap_t snap_a [MAXC];
  snap_t snap_b [MAXC];

  // Per-cycle log of outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      snap_a[cyc] = '{if_a.RdEn, if_a.RdAddr, if_a.ShowData, if_a.ShowAddr, if_a.Valid, if_a.Busy, if_a.Done};
      snap_b[cyc] = '{if_b.RdEn, if_b.RdAddr, if_b.ShowData, if_b.ShowAddr, if_b.Valid, if_b.Busy, if_b.Done};
    end
  end

  // Register file model: data valid only in the cycle READ_LAT after the strobe, X otherwise.
  int                due_a [$];
  logic [ADDR_W-1:0] pad_a [$];
  int                due_b [$];
  logic [ADDR_W-1:0] pad_b [$];

  always @(negedge clk) begin
    if (rst_a) begin
      due_a.delete();
      pad_a.delete();
    end else if (if_a.RdEn === 1'b1) begin
      due_a.push_back(cyc + LAT_A);
      pad_a.push_back(if_a.RdAddr);
    end
    if (due_a.size() > 0 && due_a[0] == cyc) begin
      if_a.RdData = regs[pad_a.pop_front()];
      void'(due_a.pop_front());
    end else begin
      if_a.RdData = 'x;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      due_b.delete();
      pad_b.delete();
    end else if (if_b.RdEn === 1'b1) begin
      due_b.push_back(cyc + LAT_B);
      pad_b.push_back(if_b.RdAddr);
    end
    if (due_b.size() > 0 && due_b[0] == cyc) begin
      if_b.RdData = regs[pad_b.pop_front()];
      void'(due_b.pop_front());
    end else begin
      if_b.RdData = 'x;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t snap_at(input int d, input int c);
    if (c < 0 || c >= MAXC) return '0;
    return (d == 0) ? snap_a[c] : snap_b[c];
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int per_of(input int d);
    return (d == 0) ? (1 + LAT_A + DW_A) : (1 + LAT_B + DW_B);
  endfunction

  function automatic int count_rden(input int d, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (snap_at(d, c).rden === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int d, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (snap_at(d, c).done === 1'b1) n++;
    return n;
  endfunction

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
  endtask

  // Checks one scan given the cycle of each register's read strobe.
  task automatic check_scan(input int d, input string tag, input int rq [NUM_REGS]);
    int    lat, per, last;
    snap_t s;
    lat  = lat_of(d);
    per  = per_of(d);
    last = rq[NUM_REGS-1] + per;
    step_to(last + 3);
    s = snap_at(d, rq[0]);
    check($sformatf("%s busy@start", tag), 32'(s.busy), 32'd1);
    check($sformatf("%s valid_clr@start", tag), 32'(s.valid), 32'd0);
    for (int k = 0; k < NUM_REGS; k++) begin
      s = snap_at(d, rq[k]);
      check($sformatf("%s rden k%0d", tag, k), 32'(s.rden), 32'd1);
      check($sformatf("%s rdaddr k%0d", tag, k), 32'(s.rdaddr), 32'(k));
      s = snap_at(d, rq[k] + 1 + lat);
      check($sformatf("%s saddr k%0d", tag, k), 32'(s.saddr), 32'(k));
      check($sformatf("%s sdata k%0d", tag, k), 32'(s.sdata), 32'(regs[k]));
      check($sformatf("%s valid k%0d", tag, k), 32'(s.valid), 32'd1);
    end
    check($sformatf("%s rden_count", tag), 32'(count_rden(d, rq[0], last + 1)), 32'(NUM_REGS));
    check($sformatf("%s done@end", tag), 32'(snap_at(d, last).done), 32'd1);
    check($sformatf("%s done_count", tag), 32'(count_done(d, rq[0], last + 2)), 32'd1);
    s = snap_at(d, last + 1);
    check($sformatf("%s busy_after", tag), 32'(s.busy), 32'd0);
    check($sformatf("%s final_sdata", tag), 32'(s.sdata), 32'(regs[NUM_REGS-1]));
    check($sformatf("%s final_saddr", tag), 32'(s.saddr), 32'(NUM_REGS - 1));
    check($sformatf("%s final_valid", tag), 32'(s.valid), 32'd1);
  endtask

  task automatic check_cleared(input int d, input string tag, input int c);
    snap_t s;
    s = snap_at(d, c);
    check($sformatf("%s rden", tag), 32'(s.rden), 32'd0);
    check($sformatf("%s rdaddr", tag), 32'(s.rdaddr), 32'd0);
    check($sformatf("%s sdata", tag), 32'(s.sdata), 32'd0);
    check($sformatf("%s saddr", tag), 32'(s.saddr), 32'd0);
    check($sformatf("%s valid", tag), 32'(s.valid), 32'd0);
    check($sformatf("%s busy", tag), 32'(s.busy), 32'd0);
    check($sformatf("%s done", tag), 32'(s.done), 32'd0);
  endtask

  int c, r, s, t2, hold;
  int rq [NUM_REGS];

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.Start = 1'b0; if_a.Pause = 1'b0; if_a.Step = 1'b0;
    if_b.Start = 1'b0; if_b.Pause = 1'b0; if_b.Step = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(16'h1000 + i);

    // Reset with Start held high: nothing may start.
    @(negedge clk);
    if_a.Start = 1'b1;
    if_b.Start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    r = cyc;
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.Start = 1'b0;
    if_b.Start = 1'b0;
    step_to(r + 3);
    check_cleared(0, "rst_a", r);
    check_cleared(1, "rst_b", r);
    check("rst_a no_rden", 32'(count_rden(0, r, r + 1)), 32'd0);
    check("rst_b no_rden", 32'(count_rden(1, r, r + 1)), 32'd0);

    // Full scan on both instances, preloaded values.
    step_to(cyc + 2);
    c = cyc;
    if_a.Start = 1'b1;
    if_b.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    if_b.Start = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) rq[k] = c + 1 + k * per_of(0);
    check_scan(0, "scan_a", rq);
    for (int k = 0; k < NUM_REGS; k++) rq[k] = c + 1 + k * per_of(1);
    check_scan(1, "scan_b", rq);

    // Pause while showing R2, Step to advance; Pause held through REQ/WAIT; Step without Pause ignored.
    randomize_regs();
    step_to(cyc + 1 + $urandom_range(0, 3));
    c = cyc;
    if_a.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    for (int k = 0; k < 3; k++) rq[k] = c + 1 + k * per_of(0);
    t2 = rq[2] + 1 + LAT_A;
    step_to(t2);
    if_a.Pause = 1'b1;
    hold = 20 + int'($urandom_range(0, 7));
    step_to(t2 + hold);
    s = cyc;
    if_a.Step = 1'b1;
    @(negedge clk);
    if_a.Step = 1'b0;
    step_to(s + 3);
    if_a.Pause = 1'b0;
    for (int k = 3; k < NUM_REGS; k++) rq[k] = s + 1 + (k - 3) * per_of(0);
    step_to(rq[4] + 1 + LAT_A);
    if_a.Step = 1'b1;
    @(negedge clk);
    if_a.Step = 1'b0;
    check("pause saddr_mid", 32'(snap_at(0, t2 + hold / 2).saddr), 32'd2);
    check("pause saddr_end", 32'(snap_at(0, s).saddr), 32'd2);
    check("pause no_rden", 32'(count_rden(0, t2, s)), 32'd0);
    check("step rdaddr", 32'(snap_at(0, s + 1).rdaddr), 32'd3);
    check("step0 no_early", 32'(count_rden(0, rq[4] + 1, rq[5] - 1)), 32'd0);
    check_scan(0, "pause_a", rq);

    // Second Start during R5 dwell is ignored.
    randomize_regs();
    step_to(cyc + 2);
    c = cyc;
    if_a.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) rq[k] = c + 1 + k * per_of(0);
    step_to(rq[5] + 1 + LAT_A + 1);
    if_a.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    check_scan(0, "restart_ign", rq);

    // Reset in R7 SHOW aborts without Done; a new Start begins again at R0.
    randomize_regs();
    step_to(cyc + 2);
    c = cyc;
    if_a.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    r = c + 1 + 7 * per_of(0) + 1 + LAT_A + 1;
    step_to(r);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    step_to(r + 130);
    check_cleared(0, "abort", r + 1);
    check("abort no_done", 32'(count_done(0, r + 1, r + 128)), 32'd0);
    check("abort no_rden", 32'(count_rden(0, r + 1, r + 128)), 32'd0);
    randomize_regs();
    c = cyc;
    if_a.Start = 1'b1;
    @(negedge clk);
    if_a.Start = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) rq[k] = c + 1 + k * per_of(0);
    check_scan(0, "after_abort", rq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
